// File: rtl/fizzbuzz_sequencer_if.sv
// Beat stream between the fizzbuzz sequencer and its downstream consumer.
// Each beat carries the integer and its divisibility flags on a valid/ready handshake.
interface fizzbuzz_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_value;
    logic             out_fizz;
    logic             out_buzz;
    logic             out_last;

    modport master (
        output out_valid,
        output out_value,
        output out_fizz,
        output out_buzz,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_value,
        input  out_fizz,
        input  out_buzz,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/fizzbuzz_sequencer.sv
// Walks 1..limit on a start command and streams each value with fizz/buzz/last flags.
// Divisibility comes from wrap-around mod-3 / mod-5 counters stepped alongside the value.
module fizzbuzz_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [WIDTH-1:0]       limit,
    input  logic                   abort,
    fizzbuzz_sequencer_if.master   out_if,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] VALUE_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] VALUE_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] limit_r;
    logic [WIDTH-1:0] limit_s;
    logic [WIDTH-1:0] value_r;
    logic [WIDTH-1:0] value_s;
    logic [1:0]       mod3_r;
    logic [1:0]       mod3_s;
    logic [2:0]       mod5_r;
    logic [2:0]       mod5_s;
    logic             valid_r;
    logic             valid_s;
    logic             fizz_r;
    logic             fizz_s;
    logic             buzz_r;
    logic             buzz_s;
    logic             last_r;
    logic             last_s;
    logic             busy_r;
    logic             busy_s;
    logic             done_r;
    logic             done_s;
    logic             xfer_s;

    function automatic logic [1:0] mod3_step(input logic [1:0] m);
        logic [1:0] r;
        if (m == 2'd2) begin
            r = 2'd0;
        end else begin
            r = m + 2'd1;
        end
        return r;
    endfunction

    function automatic logic [2:0] mod5_step(input logic [2:0] m);
        logic [2:0] r;
        if (m == 3'd4) begin
            r = 3'd0;
        end else begin
            r = m + 3'd1;
        end
        return r;
    endfunction

    // Next-state, counter stepping and next registered output values.
    always_comb begin
        xfer_s  = valid_r & out_if.out_ready;
        state_s = state_r;
        limit_s = limit_r;
        value_s = value_r;
        mod3_s  = mod3_r;
        mod5_s  = mod5_r;
        fizz_s  = 1'b0;
        buzz_s  = 1'b0;
        last_s  = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    limit_s = limit;
                    if (limit != VALUE_ZERO) begin
                        state_s = ST_RUN;
                        value_s = VALUE_ONE;
                        mod3_s  = 2'd1;
                        mod5_s  = 3'd1;
                    end else begin
                        state_s = ST_DONE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Abort wins over completion: a final beat taken with abort still ends without done.
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (xfer_s && last_r) begin
                    state_s = ST_DONE;
                end else if (xfer_s) begin
                    value_s = value_r + VALUE_ONE;
                    mod3_s  = mod3_step(mod3_r);
                    mod5_s  = mod5_step(mod5_r);
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        valid_s = (state_s == ST_RUN);
        busy_s  = (state_s == ST_RUN);
        done_s  = (state_s == ST_DONE);

        // Flags are derived from the next counters so they register together with out_value.
        if (valid_s) begin
            fizz_s = (mod3_s == 2'd0);
            buzz_s = (mod5_s == 3'd0);
            last_s = (value_s == limit_s);
        end else begin
            value_s = VALUE_ZERO;
            fizz_s  = 1'b0;
            buzz_s  = 1'b0;
            last_s  = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            limit_r <= VALUE_ZERO;
            value_r <= VALUE_ZERO;
            mod3_r  <= 2'd0;
            mod5_r  <= 3'd0;
            valid_r <= 1'b0;
            fizz_r  <= 1'b0;
            buzz_r  <= 1'b0;
            last_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            limit_r <= limit_s;
            value_r <= value_s;
            mod3_r  <= mod3_s;
            mod5_r  <= mod5_s;
            valid_r <= valid_s;
            fizz_r  <= fizz_s;
            buzz_r  <= buzz_s;
            last_r  <= last_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign out_if.out_valid = valid_r;
    assign out_if.out_value = value_r;
    assign out_if.out_fizz  = fizz_r;
    assign out_if.out_buzz  = buzz_r;
    assign out_if.out_last  = last_r;
    assign busy             = busy_r;
    assign done             = done_r;

endmodule
